mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port data memory of the rv32 core between the instruction-fetch (IF) port and the load/store (LS) port. It sequences one memory transaction at a time, tracks the fixed read latency, and routes read data back to the requester that issued the read. It sits between `risc_v`'s fetch/LSU logic and the memory macro.

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// IF/LS arbiter for the single-port data memory: one transaction at a time, fixed read latency.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of fixed LS priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = 3;

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT must be in the range 1..4");
  end

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  ls_rdata_q, ls_rdata_d;

  logic last_cyc;
  logic gnt_ok;
  logic tie_to_if;
  logic if_win;
  logic ls_win;
  logic rd_win;

  // Final WAIT cycle doubles as the rvalid cycle and a grant slot for back-to-back reads.
  assign last_cyc = (state_q == ST_WAIT) && (lat_cnt_q == CNT_W'(1));
  assign gnt_ok   = !rst && ((state_q == ST_IDLE) || last_cyc);
  assign if_win   = gnt_ok && if_req && (!ls_req || tie_to_if);
  assign ls_win   = gnt_ok && ls_req && !if_win;
  assign rd_win   = if_win || (ls_win && !ls_we);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e last_gnt_q, last_gnt_d;

  assign tie_to_if = (last_gnt_q == OWN_LS);

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (if_win) begin
      last_gnt_d = OWN_IF;
    end else if (ls_win) begin
      last_gnt_d = OWN_LS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= OWN_IF;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`else
  assign tie_to_if = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_cnt_d  = lat_cnt_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;

    if_gnt    = if_win;
    ls_gnt    = ls_win;
    mem_en    = if_win || ls_win;
    mem_we    = (ls_win && ls_we) ? ls_be : '0;
    mem_addr  = if_win ? if_addr : (ls_win ? ls_addr : '0);
    mem_wdata = ls_win ? ls_wdata : '0;
    busy      = !rst && (state_q == ST_WAIT);

    if_rvalid = !rst && last_cyc && (owner_q == OWN_IF);
    ls_rvalid = !rst && last_cyc && (owner_q == OWN_LS);

    if (if_rvalid) begin
      if_rdata_d = mem_rdata;
    end
    if (ls_rvalid) begin
      ls_rdata_d = mem_rdata;
    end

    // Non-owner keeps presenting its last returned word.
    if_rdata = rst ? '0 : (if_rvalid ? mem_rdata : if_rdata_q);
    ls_rdata = rst ? '0 : (ls_rvalid ? mem_rdata : ls_rdata_q);

    if (state_q == ST_WAIT) begin
      if (last_cyc) begin
        state_d = ST_IDLE;
      end else begin
        lat_cnt_d = lat_cnt_q - CNT_W'(1);
      end
    end

    if (rd_win) begin
      state_d   = ST_WAIT;
      lat_cnt_d = CNT_W'(MEM_LAT);
      owner_d   = if_win ? OWN_IF : OWN_LS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      lat_cnt_q  <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_cnt_q  <= lat_cnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  logic unused_be_w;
  assign unused_be_w = ^BE_W;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (MEM_LAT = 1, 2, 3) share one set of inputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_we;
  logic [3:0]  ls_be;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;

  wire         if_gnt_w    [3];
  wire         if_rvalid_w [3];
  wire  [31:0] if_rdata_w  [3];
  wire         ls_gnt_w    [3];
  wire         ls_rvalid_w [3];
  wire  [31:0] ls_rdata_w  [3];
  wire         mem_en_w    [3];
  wire  [3:0]  mem_we_w    [3];
  wire  [31:0] mem_addr_w  [3];
  wire  [31:0] mem_wdata_w [3];
  wire         busy_w      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[g]),
      .if_rvalid(if_rvalid_w[g]), .if_rdata(if_rdata_w[g]),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt_w[g]),
      .ls_rvalid(ls_rvalid_w[g]), .ls_rdata(ls_rdata_w[g]),
      .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]), .mem_addr(mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]), .mem_rdata(mem_rdata), .busy(busy_w[g])
    );
  end

  typedef struct packed {
    logic        rst, if_req, ls_req, ls_we;
    logic [3:0]  ls_be;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic        e_if_gnt, e_ls_gnt, e_mem_en;
    logic [3:0]  e_mem_we;
    logic [31:0] e_mem_addr, e_mem_wdata;
    logic        e_if_rvalid, e_ls_rvalid;
    logic [31:0] e_if_rdata, e_ls_rdata;
    logic        e_busy;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ifr, input logic lsr, input logic we,
                       input logic [3:0] be, input logic [31:0] ifa, input logic [31:0] lsa,
                       input logic [31:0] wd, input logic [31:0] mr);
    rst = r; if_req = ifr; ls_req = lsr; ls_we = we; ls_be = be;
    if_addr = ifa; ls_addr = lsa; ls_wdata = wd; mem_rdata = mr;
  endtask

  task automatic reset_all(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    // rst ifr lsr we be ifa lsa wdata mrdata | ifg lsg en we addr wdata ifrv lsrv ifrd lsrd busy
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h100, 32'h40, 32'h11, 32'h99,
                 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h0, 32'h99,
                 1'b1, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF,
                 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h0, 32'h40, 32'h12345678, 32'hAAAAAAAA,
                 1'b0, 1'b1, 1'b1, 4'h3, 32'h40, 32'h12345678, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0, 32'h44, 32'h77, 32'hAAAAAAAA,
                 1'b0, 1'b1, 1'b1, 4'h0, 32'h44, 32'h77, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h80, 32'h55, 32'hAAAAAAAA,
                 1'b0, 1'b1, 1'b1, 4'h0, 32'h80, 32'h55, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h104, 32'h0, 32'h0, 32'hCAFEF00D,
                 1'b1, 1'b0, 1'b1, 4'h0, 32'h104, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h01020304,
                 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h01020304, 32'hCAFEF00D, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'hBBBBBBBB,
                 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h01020304, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h108, 32'h0, 32'h0, 32'hBBBBBBBB,
                 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'hBBBBBBBB,
                 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};

    reset_all(2);

    // Table vectors against the MEM_LAT=1 instance.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].if_req, vecs[i].ls_req, vecs[i].ls_we, vecs[i].ls_be,
            vecs[i].if_addr, vecs[i].ls_addr, vecs[i].ls_wdata, vecs[i].mem_rdata);
      #1;
      chk($sformatf("v%0d if_gnt", i),    if_gnt_w[0],    vecs[i].e_if_gnt);
      chk($sformatf("v%0d ls_gnt", i),    ls_gnt_w[0],    vecs[i].e_ls_gnt);
      chk($sformatf("v%0d mem_en", i),    mem_en_w[0],    vecs[i].e_mem_en);
      chk($sformatf("v%0d mem_we", i),    mem_we_w[0],    vecs[i].e_mem_we);
      chk($sformatf("v%0d if_rvalid", i), if_rvalid_w[0], vecs[i].e_if_rvalid);
      chk($sformatf("v%0d ls_rvalid", i), ls_rvalid_w[0], vecs[i].e_ls_rvalid);
      chk($sformatf("v%0d if_rdata", i),  if_rdata_w[0],  vecs[i].e_if_rdata);
      chk($sformatf("v%0d ls_rdata", i),  ls_rdata_w[0],  vecs[i].e_ls_rdata);
      chk($sformatf("v%0d busy", i),      busy_w[0],      vecs[i].e_busy);
      if (vecs[i].e_mem_en) begin
        chk($sformatf("v%0d mem_addr", i),  mem_addr_w[0],  vecs[i].e_mem_addr);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata_w[0], vecs[i].e_mem_wdata);
      end
    end

    // MEM_LAT=3: IF and LS reads raised together straight out of reset.
    reset_all(2);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(1'b0, (c < 4), (c == 0), 1'b0, 4'hF, 32'h100, 32'h200, 32'h0,
            (c == 3) ? 32'h33333333 : ((c == 6) ? 32'h66666666 : 32'h0));
      #1;
      chk($sformatf("lat3 c%0d ls_gnt", c),    ls_gnt_w[2],    (c == 0));
      chk($sformatf("lat3 c%0d if_gnt", c),    if_gnt_w[2],    (c == 3));
      chk($sformatf("lat3 c%0d ls_rvalid", c), ls_rvalid_w[2], (c == 3));
      chk($sformatf("lat3 c%0d if_rvalid", c), if_rvalid_w[2], (c == 6));
      chk($sformatf("lat3 c%0d busy", c),      busy_w[2],      (c >= 1 && c <= 6));
      if (c == 3) chk("lat3 ls_rdata", ls_rdata_w[2], 32'h33333333);
      if (c == 6) chk("lat3 if_rdata", if_rdata_w[2], 32'h66666666);
    end

    // MEM_LAT=1: both requesters read continuously for 10 cycles.
    reset_all(1);
    for (int c = 0; c < 10; c++) begin
      logic exp_ls;
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h300, 32'h400, 32'h0, 32'h0);
      #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_ls = (c % 2 == 0);
`else
      exp_ls = 1'b1;
`endif
      chk($sformatf("tie c%0d ls_gnt", c),   ls_gnt_w[0],   exp_ls);
      chk($sformatf("tie c%0d if_gnt", c),   if_gnt_w[0],   !exp_ls);
      chk($sformatf("tie c%0d mem_addr", c), mem_addr_w[0], exp_ls ? 32'h400 : 32'h300);
    end

    // MEM_LAT=2: reset pulse aborts an outstanding IF read.
    reset_all(2);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h500, 32'h0, 32'h0, 32'h0);
    #1;
    chk("abort grant if_gnt", if_gnt_w[1], 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h500, 32'h44, 32'h9, 32'hEEEEEEEE);
    #1;
    chk("rst if_gnt",    if_gnt_w[1],    1'b0);
    chk("rst ls_gnt",    ls_gnt_w[1],    1'b0);
    chk("rst mem_en",    mem_en_w[1],    1'b0);
    chk("rst mem_we",    mem_we_w[1],    4'h0);
    chk("rst mem_addr",  mem_addr_w[1],  32'h0);
    chk("rst mem_wdata", mem_wdata_w[1], 32'h0);
    chk("rst if_rvalid", if_rvalid_w[1], 1'b0);
    chk("rst ls_rvalid", ls_rvalid_w[1], 1'b0);
    chk("rst if_rdata",  if_rdata_w[1],  32'h0);
    chk("rst ls_rdata",  ls_rdata_w[1],  32'h0);
    chk("rst busy",      busy_w[1],      1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h600, 32'h0, 32'h0, 32'hEEEEEEEE);
    #1;
    chk("post-rst if_rvalid", if_rvalid_w[1], 1'b0);
    chk("post-rst busy",      busy_w[1],      1'b0);
    chk("post-rst if_gnt",    if_gnt_w[1],    1'b1);
    chk("post-rst mem_addr",  mem_addr_w[1],  32'h600);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'hEEEEEEEE);
    #1;
    chk("new read wait if_rvalid", if_rvalid_w[1], 1'b0);
    chk("new read wait busy",      busy_w[1],      1'b1);
    @(negedge clk);
    #1;
    chk("new read if_rvalid", if_rvalid_w[1], 1'b1);
    chk("new read if_rdata",  if_rdata_w[1],  32'hEEEEEEEE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
